// File: rtl/uart_rx_framed_if.sv
// Receiver-side signal bundle: serial line in, one framed result word out.
// valid is a one-cycle strobe with no ready; result/frame_err/parity_err are only
// meaningful while valid is high and hold until the next strobe overwrites them.
interface uart_rx_framed_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 valid;
  logic [DATA_BITS-1:0] result;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output rx,
    input  valid, result, frame_err, parity_err, busy
  );

  modport slave (
    input  rx,
    output valid, result, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_framed.sv
// Oversampled UART receiver: synchronised rx, mid-bit sampling, start-glitch rejection,
// optional parity and stop-bit framing check; one valid strobe per frame.
module uart_rx_framed #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  uart_rx_framed_if.slave   bus,
  output logic [2:0]        o_dbg_state
);

  localparam int   HALF    = CLKS_PER_BIT / 2;
  localparam int   CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int   BIT_W   = $clog2(DATA_BITS + 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_baud;
  logic [BIT_W-1:0]       r_bit;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_par;
  logic                   r_valid;
  logic [DATA_BITS-1:0]   r_result;
  logic                   r_frame_err;
  logic                   r_parity_err;

  logic w_rx_s;
  logic w_half;
  logic w_full;
  logic w_last_bit;

  assign w_rx_s     = r_sync[SYNC_STAGES-1];
  assign w_half     = (r_baud == CNT_W'(HALF - 1));
  assign w_full     = (r_baud == CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit == BIT_W'(DATA_BITS - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_rx_s) w_state_nxt = S_START;
      S_START:  if (w_half) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (w_full && w_last_bit) w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_full) w_state_nxt = S_STOP;
      S_STOP:   if (w_full) w_state_nxt = w_rx_s ? S_IDLE : S_BREAK;
      S_BREAK:  if (w_rx_s) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync       <= '1;
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit        <= '0;
      r_data       <= '0;
      r_par        <= 1'b0;
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.rx};
      r_state <= w_state_nxt;
      r_valid <= 1'b0;

      // START times the half bit; every later state runs on full-bit wraps
      case (r_state)
        S_IDLE, S_BREAK: r_baud <= '0;
        S_START: begin
          r_baud <= w_half ? '0 : r_baud + 1'b1;
          r_bit  <= '0;
          r_par  <= 1'b0;
        end
        default: r_baud <= w_full ? '0 : r_baud + 1'b1;
      endcase

      if (w_full) begin
        case (r_state)
          S_DATA: begin
            r_data <= {w_rx_s, r_data[DATA_BITS-1:1]};
            r_par  <= r_par ^ w_rx_s;
            r_bit  <= r_bit + 1'b1;
          end
          S_PARITY: r_par <= r_par ^ w_rx_s;
          S_STOP: begin
            r_valid      <= 1'b1;
            r_result     <= r_data;
            r_frame_err  <= ~w_rx_s;
            r_parity_err <= (PARITY_EN != 0) && (r_par != PAR_ODD);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.valid      = r_valid;
  assign bus.result     = r_result;
  assign bus.frame_err  = r_frame_err;
  assign bus.parity_err = r_parity_err;
  assign bus.busy       = (r_state != S_IDLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: an 8N1 instance and an 8E1 instance on one clock,
// scoreboard queues of expected {parity_err, frame_err, result} per valid strobe.
module tb_uart_rx_framed;

  localparam int CPB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_framed_if #(.DATA_BITS(8)) if_n ();
  uart_rx_framed_if #(.DATA_BITS(8)) if_p ();
  logic [2:0] st_n;
  logic [2:0] st_p;

  uart_rx_framed #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)
  ) dut_n (
    .clk(clk), .rst(rst), .bus(if_n.slave), .o_dbg_state(st_n)
  );

  uart_rx_framed #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)
  ) dut_p (
    .clk(clk), .rst(rst), .bus(if_p.slave), .o_dbg_state(st_p)
  );

  // scoreboard
  int tests_run    = 0;
  int tests_failed = 0;
  logic [9:0] exp_q_n[$];
  logic [9:0] exp_q_p[$];
  int n_valid = 0, p_valid = 0;
  int n_busy  = 0;
  int n_last_cyc = 0, p_last_cyc = 0;
  int t_start = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (if_n.valid) begin
      n_valid++;
      n_last_cyc = cyc;
      if (exp_q_n.size() == 0) check("n_unexpected_valid", 32'd1, 32'd0);
      else check("n_sb_word", {if_n.parity_err, if_n.frame_err, if_n.result}, exp_q_n.pop_front());
    end
    if (if_n.busy) n_busy++;
    if (if_p.valid) begin
      p_valid++;
      p_last_cyc = cyc;
      if (exp_q_p.size() == 0) check("p_unexpected_valid", 32'd1, 32'd0);
      else check("p_sb_word", {if_p.parity_err, if_p.frame_err, if_p.result}, exp_q_p.pop_front());
    end
  end

  // driver tasks; all drives land 1 time unit after a rising edge
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit par, input logic b, input int n);
    if (par) if_p.rx = b;
    else     if_n.rx = b;
    wait_cyc(n);
  endtask

  task automatic send_frame(input bit par, input logic [7:0] data, input logic pbit,
                            input logic sbit);
    logic pe;
    pe = par ? ((^data) ^ pbit) : 1'b0;
    if (par) exp_q_p.push_back({pe, ~sbit, data});
    else     exp_q_n.push_back({pe, ~sbit, data});
    t_start = cyc;
    drive_bit(par, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(par, data[i], CPB);
    if (par) drive_bit(par, pbit, CPB);
    drive_bit(par, sbit, CPB);
  endtask

  int v0, b0;
  logic [7:0] d55;

  initial begin
    rst     = 1'b1;
    if_n.rx = 1'b1;
    if_p.rx = 1'b1;
    wait_cyc(3);
    check("rst_valid", if_n.valid, 1'b0);
    check("rst_result", if_n.result, 8'h00);
    check("rst_busy", if_n.busy, 1'b0);
    check("rst_state", st_n, 3'd0);
    check("rst_p_flags", {if_p.valid, if_p.frame_err, if_p.parity_err}, 3'b000);
    rst = 1'b0;
    wait_cyc(4);

    // 1: 0xA5 8N1, latency 2 + 2 + 9*4 + 1
    v0 = n_valid;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    wait_cyc(3);
    check("t1_valid_count", n_valid - v0, 1);
    check("t1_result", if_n.result, 8'hA5);
    check("t1_flags", {if_n.frame_err, if_n.parity_err}, 2'b00);
    check("t1_latency", n_last_cyc - t_start, 41);
    wait_cyc(4);

    // 2: one-cycle glitch is rejected in START
    v0 = n_valid;
    b0 = n_busy;
    drive_bit(1'b0, 1'b0, 1);
    drive_bit(1'b0, 1'b1, 10);
    check("t2_no_valid", n_valid - v0, 0);
    check("t2_busy_seen", (n_busy - b0) > 0, 1'b1);
    check("t2_busy_bound", (n_busy - b0) <= 3, 1'b1);
    check("t2_state_idle", st_n, 3'd0);

    // 3: bad stop bit, line held low -> frame_err then BREAK
    v0 = n_valid;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    wait_cyc(20);
    check("t3_valid_count", n_valid - v0, 1);
    check("t3_result", if_n.result, 8'h3C);
    check("t3_frame_err", if_n.frame_err, 1'b1);
    check("t3_state_break", st_n, 3'd5);
    drive_bit(1'b0, 1'b1, 10);
    check("t3_state_idle", st_n, 3'd0);
    check("t3_no_second_valid", n_valid - v0, 1);

    // 4: even parity on 0x07 (three ones): parity bit 1 is good, 0 is bad
    send_frame(1'b1, 8'h07, 1'b1, 1'b1);
    wait_cyc(3);
    check("t4_good_pe", if_p.parity_err, 1'b0);
    check("t4_good_result", if_p.result, 8'h07);
    check("t4_latency", p_last_cyc - t_start, 45);
    wait_cyc(4);
    send_frame(1'b1, 8'h07, 1'b0, 1'b1);
    wait_cyc(3);
    check("t4_bad_pe", if_p.parity_err, 1'b1);
    check("t4_bad_result", if_p.result, 8'h07);
    check("t4_bad_fe", if_p.frame_err, 1'b0);
    check("t4_p_valid_count", p_valid, 2);
    wait_cyc(4);

    // 5: back-to-back frames with no idle gap
    v0 = n_valid;
    send_frame(1'b0, 8'h00, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1);
    wait_cyc(3);
    check("t5_valid_count", n_valid - v0, 2);
    check("t5_last_result", if_n.result, 8'hFF);
    wait_cyc(4);

    // 6: reset in the middle of 0x55's data bits aborts the frame
    v0  = n_valid;
    d55 = 8'h55;
    drive_bit(1'b0, 1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, d55[i], CPB);
    check("t6_busy_before", if_n.busy, 1'b1);
    rst     = 1'b1;
    if_n.rx = 1'b1;
    wait_cyc(1);
    check("t6_rst_outputs", {if_n.valid, if_n.frame_err, if_n.parity_err, if_n.busy}, 4'b0000);
    check("t6_rst_result", if_n.result, 8'h00);
    check("t6_rst_state", st_n, 3'd0);
    rst = 1'b0;
    wait_cyc(6);
    check("t6_no_valid", n_valid - v0, 0);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    wait_cyc(3);
    check("t6_next_count", n_valid - v0, 1);
    check("t6_next_result", if_n.result, 8'h81);

    wait_cyc(5);
    check("n_queue_drained", exp_q_n.size(), 0);
    check("p_queue_drained", exp_q_p.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
